fb_ram_arbiter: RTL
===================

# fb_ram_arbiter

Access arbiter for one 512x8 pseudo-dual-port frame-buffer RAM (RAM_PDP_512x8) in the display frame buffer demo. Shares the RAM between two clients: the display scanout engine, which is read-only, and the host (SPI) client, which reads and writes. Host writes go straight to the dedicated write port. Reads from both clients compete for the single read port under display-priority arbitration with a host starvation guard. A same-cycle write-to-read bypass hides the RAM's undefined read-during-write behaviour.

## Interface
- ADDR_W, 9, RAM address width
- DATA_W, 8, RAM data width
- STARVE_MAX, 4, consecutive denied host-read cycles before the host is forced a grant (range 1..15)

- clk  in  1  single clock for arbiter and RAM (both wclk and rclk)
- rst_n  in  1  asynchronous, active-low reset
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display read accepted this cycle
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- host_req  in  1  host request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- ram_waddr, ram_din, ram_write_en  out  ADDR_W/DATA_W/1  to RAM write port
- ram_raddr, ram_read_en  out  ADDR_W/1  to RAM read port
- ram_dout  in  DATA_W  from RAM, valid the cycle after ram_read_en

## Operation
- Handshake: a transfer occurs in a cycle where req and gnt are both high. Grants are combinational from the current requests and state. A requester holds req, addr and wdata stable until granted.
- Host write (host_req and host_we): always granted. ram_write_en=1, ram_waddr=host_addr, ram_din=host_wdata in the same cycle.
- Read arbitration covers the display read and the host read (host_req and !host_we):
  - Default: the display wins.
  - starve_cnt (4 bits) increments on each cycle a host read is pending and denied.
  - When starve_cnt==STARVE_MAX, the host wins that cycle even if the display requests.
  - starve_cnt clears on a host read grant, and on any cycle with no pending host read.
  - A lone requester is always granted.
- Read issue: the winner drives ram_raddr, with ram_read_en=1.
  - Registered state: rd_owner (display/host) and rd_inflight.
- Bypass: if a read is granted and ram_write_en=1 with ram_waddr==ram_raddr in the same cycle:
  - byp_hit<=1 and byp_data<=host_wdata.
  - Next cycle the owner's rdata = byp_data instead of ram_dout.
- Read response: in cycle N+1 after a grant in cycle N, the owner's rvalid=1 and its rdata = (byp_hit ? byp_data : ram_dout). The other client's rvalid=0.
- rdata is only meaningful while the matching rvalid=1. It is driven 0 otherwise.
- Back-to-back reads are allowed every cycle. There is no output backpressure: clients must accept rvalid.

## Timing
- Reset values: rd_inflight=0, rd_owner=display, starve_cnt=0, byp_hit=0, byp_data=0.
  - disp_rvalid=host_rvalid=0 and disp_rdata=host_rdata=0.
  - While rst_n=0, disp_gnt, host_gnt, ram_read_en and ram_write_en are forced 0.
- Write latency: 0 cycles (RAM updated at the end of the grant cycle).
- Read latency: exactly 1 cycle, grant to rvalid.
- Host write and display read in the same cycle: both granted, with bypass if the addresses match.
- Host cannot read and write in one cycle (single channel).
- Reset asserted while a read is in flight: the response is dropped and rvalid stays 0.
- Address wrap: none. Addresses are passed through unchanged, covering 0x000..0x1FF.
- starve_cnt saturates at STARVE_MAX and never wraps.

## Structure
- Package fb_arb_pkg holds:
  - localparams FB_ADDR_W=9 and FB_DATA_W=8.
  - A client enum {CL_DISP, CL_HOST} used for rd_owner.
- Sub-module fb_starve_guard holds starve_cnt and the force_host output.
  - Inputs: host_rd_pend, host_rd_gnt.
- The RAM is instantiated outside the arbiter, in the frame-buffer top level. The bench instantiates RAM_PDP_512x8 alongside the arbiter.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> both gnts=0, both rvalids=0, ram enables=0. After release, the first grant goes to the display.
- Display read: RAM[0x010]=0xA5, disp_req addr 0x010 -> disp_gnt in the same cycle, disp_rvalid=1 with disp_rdata=0xA5 one cycle later, host_rvalid=0.
- Host write then read:
  - Write 0x1FF=0x3C -> granted immediately.
  - Next cycle, read 0x1FF -> host_rvalid with host_rdata=0x3C one cycle after the grant.
- Contention with STARVE_MAX=4: display and host read every cycle -> display granted 4 cycles, host granted on the 5th, pattern repeats. Each rvalid goes to the correct client with the correct data.
- Bypass: RAM[0x020]=0x11; host writes 0x020=0x77 in the same cycle the display reads 0x020 -> disp_rdata=0x77 next cycle. Reading 0x020 again returns 0x77 from the RAM.
- Reset mid-read: display read granted in cycle N, rst_n=0 in N+1 -> disp_rvalid=0 and starve_cnt=0. After release, normal operation resumes.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and sizes for the frame-buffer RAM arbiter.
package fb_arb_pkg;

  localparam int unsigned FB_ADDR_W  = 9;
  localparam int unsigned FB_DATA_W  = 8;
  localparam int unsigned STARVE_W   = 4;

  // Client that owns the read currently in flight.
  typedef enum logic {
    CL_DISP = 1'b0,
    CL_HOST = 1'b1
  } client_e;

endpackage : fb_arb_pkg

// File: rtl/RAM_PDP_512x8.sv
// Behavioural stand-in for the 512x8 pseudo-dual-port RAM macro.
// Registered read (data valid the cycle after read_en); a read of the address
// being written in the same cycle returns the old contents.
//   wclk, write_en, waddr, din : write port
//   rclk, read_en, raddr, dout : read port
module RAM_PDP_512x8 (
  input  logic       wclk,
  input  logic       write_en,
  input  logic [8:0] waddr,
  input  logic [7:0] din,
  input  logic       rclk,
  input  logic       read_en,
  input  logic [8:0] raddr,
  output logic [7:0] dout
);

  logic [7:0] mem [512];

  always_ff @(posedge wclk) begin
    if (write_en) begin
      mem[waddr] <= din;
    end
  end

  always_ff @(posedge rclk) begin
    if (read_en) begin
      dout <= mem[raddr];
    end
  end

endmodule : RAM_PDP_512x8

// File: rtl/fb_starve_guard.sv
// Host starvation guard: counts consecutive cycles a host read is pending and
// denied, and forces a host grant once the count reaches STARVE_MAX.
//   clk, rst_n    : clock, async active-low reset
//   host_rd_pend  : a host read is requesting this cycle
//   host_rd_gnt   : the host read won arbitration this cycle
//   force_host    : host must win this cycle regardless of the display
module fb_starve_guard
  import fb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic host_rd_pend,
  input  logic host_rd_gnt,
  output logic force_host
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;

  // Clear on grant or idle host, otherwise count up and saturate.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!host_rd_pend || host_rd_gnt) begin
      starve_nxt = '0;
    end else if (starve_cnt < CNT_MAX) begin
      starve_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  assign force_host = (starve_cnt == CNT_MAX);

endmodule : fb_starve_guard

// File: rtl/fb_ram_arbiter.sv
// Arbiter sharing one pseudo-dual-port frame-buffer RAM between the display
// scanout (read only) and the host (read/write). Host writes go straight to the
// write port; reads compete for the read port with display priority and a host
// starvation guard. A same-cycle write-to-read bypass masks the RAM's
// undefined read-during-write result.
//   disp_req/addr -> disp_gnt, disp_rvalid/rdata       display read channel
//   host_req/we/addr/wdata -> host_gnt, host_rvalid/rdata   host channel
//   ram_waddr/din/write_en, ram_raddr/read_en, ram_dout     RAM ports
module fb_ram_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned DATA_W     = FB_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_read_en,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              host_rd;
  logic              host_wr;
  logic              force_host;
  logic              host_rd_win;
  logic              disp_win;
  logic              rd_win;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              rd_inflight;
  logic              rd_inflight_nxt;
  client_e           rd_owner;
  client_e           rd_owner_nxt;
  logic              byp_hit;
  logic              byp_hit_nxt;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] byp_data_nxt;

  // Read arbitration: display by default, host when alone or when forced.
  always_comb begin
    host_wr     = host_req & host_we;
    host_rd     = host_req & ~host_we;
    host_rd_win = host_rd & (~disp_req | force_host);
    disp_win    = disp_req & ~host_rd_win;
    rd_win      = disp_win | host_rd_win;
    rd_addr     = host_rd_win ? host_addr : disp_addr;
  end

  fb_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_guard (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_rd_pend (host_rd),
    .host_rd_gnt  (host_rd_win),
    .force_host   (force_host)
  );

  // Grants and RAM enables are held low for the whole reset window.
  assign disp_gnt     = rst_n & disp_win;
  assign host_gnt     = rst_n & (host_wr | host_rd_win);
  assign ram_write_en = rst_n & host_wr;
  assign ram_waddr    = host_addr;
  assign ram_din      = host_wdata;
  assign ram_read_en  = rst_n & rd_win;
  assign ram_raddr    = rd_addr;

  // Track the read in flight; capture write data when it collides with the read.
  always_comb begin
    rd_inflight_nxt = rd_win;
    rd_owner_nxt    = rd_owner;
    byp_hit_nxt     = 1'b0;
    byp_data_nxt    = byp_data;
    if (rd_win) begin
      rd_owner_nxt = host_rd_win ? CL_HOST : CL_DISP;
    end
    if (rd_win && host_wr && (host_addr == rd_addr)) begin
      byp_hit_nxt  = 1'b1;
      byp_data_nxt = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      rd_owner    <= CL_DISP;
      byp_hit     <= 1'b0;
      byp_data    <= '0;
    end else begin
      rd_inflight <= rd_inflight_nxt;
      rd_owner    <= rd_owner_nxt;
      byp_hit     <= byp_hit_nxt;
      byp_data    <= byp_data_nxt;
    end
  end

  // Response steering: RAM data arrives the cycle after issue, so this path
  // stays combinational from ram_dout.
  always_comb begin
    rd_data     = byp_hit ? byp_data : ram_dout;
    disp_rvalid = rd_inflight & (rd_owner == CL_DISP);
    host_rvalid = rd_inflight & (rd_owner == CL_HOST);
    disp_rdata  = disp_rvalid ? rd_data : '0;
    host_rdata  = host_rvalid ? rd_data : '0;
  end

endmodule : fb_ram_arbiter
